// File: rtl/stream_hsmooth_if.sv
// Avalon-ST style video stream bundle: 24-bit data plus valid/ready handshake
// and sop/eop packet framing. The master drives the word; the slave drives ready.
interface stream_hsmooth_if;
    logic [23:0] data;
    logic        valid;
    logic        ready;
    logic        sop;
    logic        eop;

    modport master (output data, output valid, output sop, output eop, input ready);
    modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/stream_hsmooth.sv
// Horizontal [1 2 1]/4 smoothing of RGB video packets ahead of colour detection.
// Video packets with the filter enabled are smoothed per channel with edge
// replication at both line ends. Control packets and bypassed frames are
// forwarded unchanged. Framing and backpressure are preserved through a single
// registered output stage.
module stream_hsmooth #(
    parameter int IMAGE_W = 640
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    stream_hsmooth_if.slave         sink,
    stream_hsmooth_if.master        source
);

    localparam int XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,   // between packets: stray words forwarded as-is
        S_PASS,   // control packet or bypassed video frame
        S_FIRST,  // waiting for the first pixel of a line
        S_RUN,    // filtering inside a line
        S_FLUSH   // emitting the right-edge pixel of a line
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [23:0]   prev_q, prev_d;
    logic [23:0]   cur_q, cur_d;
    logic          eop_pend_q, eop_pend_d;

    logic [23:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;

    logic          out_free;
    logic          accept;
    logic          line_end;

    // Per-channel (a + 2b + c) >> 2; a 10-bit sum cannot overflow for 8-bit inputs.
    function automatic logic [23:0] smooth(input logic [23:0] a,
                                           input logic [23:0] b,
                                           input logic [23:0] c);
        logic [9:0]  sum;
        logic [23:0] res;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sum = 10'(a[ch*8 +: 8]) + {1'b0, b[ch*8 +: 8], 1'b0} + 10'(c[ch*8 +: 8]);
            res[ch*8 +: 8] = sum[9:2];
        end
        return res;
    endfunction

    assign out_free    = ~valid_q | source.ready;
    assign sink.ready  = out_free & (state_q != S_FLUSH) & reset_n;
    assign accept      = sink.valid & sink.ready;
    assign line_end    = sink.eop | (x_q == X_LAST);

    assign source.data  = data_q;
    assign source.valid = valid_q;
    assign source.sop   = sop_q;
    assign source.eop   = eop_q;

    // Next-state, pixel pipeline and output-register load decisions.
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this combinational block latch-free.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        eop_pend_d = eop_pend_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sop_d      = sop_q;
        eop_d      = eop_q;

        // A free output register empties unless something below reloads it.
        if (out_free) begin
            valid_d = 1'b0;
        end

        if (accept && sink.sop) begin
            // Descriptor word: restarts framing from any state, dropping held pixels.
            data_d     = sink.data;
            valid_d    = 1'b1;
            sop_d      = 1'b1;
            eop_d      = sink.eop;
            prev_d     = '0;
            cur_d      = '0;
            eop_pend_d = 1'b0;
            x_d        = '0;
            state_d    = ((sink.data[3:0] == 4'h0) && enable) ? S_FIRST : S_PASS;
        end else if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    data_d  = sink.data;
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = sink.eop;
                end
                S_PASS: begin
                    data_d  = sink.data;
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = sink.eop;
                    if (sink.eop) begin
                        state_d = S_IDLE;
                    end
                end
                S_FIRST: begin
                    // Left edge: replicate the first pixel as its own left neighbour.
                    prev_d = sink.data;
                    cur_d  = sink.data;
                    x_d    = x_q + XW'(1);
                    if (line_end) begin
                        eop_pend_d = sink.eop;
                        state_d    = S_FLUSH;
                    end else begin
                        state_d    = S_RUN;
                    end
                end
                S_RUN: begin
                    data_d  = smooth(prev_q, cur_q, sink.data);
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    prev_d  = cur_q;
                    cur_d   = sink.data;
                    x_d     = x_q + XW'(1);
                    if (line_end) begin
                        eop_pend_d = sink.eop;
                        state_d    = S_FLUSH;
                    end
                end
                default: ;
            endcase
        end else if (state_q == S_FLUSH && out_free) begin
            // Right edge: replicate the last pixel as its own right neighbour.
            data_d     = smooth(prev_q, cur_q, cur_q);
            valid_d    = 1'b1;
            sop_d      = 1'b0;
            eop_d      = eop_pend_q;
            x_d        = '0;
            eop_pend_d = 1'b0;
            state_d    = eop_pend_q ? S_IDLE : S_FIRST;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed above regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            prev_q     <= '0;
            cur_q      <= '0;
            eop_pend_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            eop_pend_q <= eop_pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
        end
    end

endmodule

// File: tb/tb_stream_hsmooth.sv
// Scoreboard bench for stream_hsmooth: stimulus pushes expected output words,
// an independent monitor pops and compares on every output transfer.
module tb_stream_hsmooth;

    localparam int W = 640;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;

    always #5 clk = ~clk;

    stream_hsmooth_if sink_if ();
    stream_hsmooth_if src_if ();

    stream_hsmooth #(.IMAGE_W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .sink    (sink_if),
        .source  (src_if)
    );

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    word_t       exp_q[$];
    logic [23:0] pix_q[$];

    int n_cmp        = 0;
    int n_bad        = 0;
    int out_count    = 0;
    int stall_cycles = 0;
    bit rand_ready   = 1'b0;
    bit rand_gap     = 1'b0;
    bit ignore_out   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference smoothing from the filter definition, integer arithmetic per channel.
    function automatic logic [23:0] ref_smooth(input logic [23:0] l, input logic [23:0] c,
                                               input logic [23:0] r);
        logic [23:0] o;
        int          s;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'(l[ch*8 +: 8]) + 2 * int'(c[ch*8 +: 8]) + int'(r[ch*8 +: 8]);
            o[ch*8 +: 8] = 8'(s / 4);
        end
        return o;
    endfunction

    // Downstream ready: constant 1 or a 50% random pattern.
    initial begin
        src_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            src_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares every transferred word and checks stability while stalled.
    initial begin
        word_t got;
        word_t held;
        word_t exp;
        bit    prev_stall;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!reset_n || ignore_out) begin
                prev_stall = 1'b0;
            end else begin
                got = {src_if.data, src_if.sop, src_if.eop};
                if (prev_stall) begin
                    check("stall_valid_held", 32'(src_if.valid), 32'd1);
                    check("stall_word_held", 32'(got), 32'(held));
                end
                if (src_if.valid && src_if.ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h expected none", got);
                    end else begin
                        exp = exp_q.pop_front();
                        check("out_word", 32'(got), 32'(exp));
                        out_count++;
                    end
                end
                prev_stall = src_if.valid && !src_if.ready;
                held       = got;
            end
        end
    end

    // Drive one word and wait (bounded) for it to be accepted.
    task automatic send_word(input logic [23:0] d, input logic s, input logic e);
        bit acc;
        int waits;
        acc   = 1'b0;
        waits = 0;
        if (rand_gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        sink_if.data  = d;
        sink_if.sop   = s;
        sink_if.eop   = e;
        sink_if.valid = 1'b1;
        while (!acc && waits < 1000) begin
            @(negedge clk);
            acc = sink_if.ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        stall_cycles += waits;
        sink_if.valid = 1'b0;
        sink_if.sop   = 1'b0;
        sink_if.eop   = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sink_accept: got no ready expected ready within 1000 cycles");
        end
    endtask

    // Send descriptor + pix_q; optionally model the expected output first.
    // term_eop=0 means the packet is cut short by the next sop.
    task automatic send_packet(input logic [23:0] desc, input bit term_eop,
                               input int toggle_at, input bit model);
        int  n;
        bit  video;
        int  m;
        int  emit;
        n     = pix_q.size();
        video = (desc[3:0] == 4'h0) && enable;
        if (model) begin
            exp_q.push_back({desc, 1'b1, 1'(term_eop && n == 0)});
            if (!video) begin
                for (int i = 0; i < n; i++)
                    exp_q.push_back({pix_q[i], 1'b0, 1'(term_eop && i == n - 1)});
            end else begin
                for (int s = 0; s < n; s += W) begin
                    m    = (n - s < W) ? n - s : W;
                    emit = (term_eop || m == W) ? m : m - 1;
                    for (int i = 0; i < emit; i++) begin
                        exp_q.push_back({ref_smooth(pix_q[s + ((i > 0) ? i - 1 : i)],
                                                    pix_q[s + i],
                                                    pix_q[s + ((i < m - 1) ? i + 1 : i)]),
                                         1'b0, 1'(term_eop && i == m - 1 && s + m == n)});
                    end
                end
            end
        end
        send_word(desc, 1'b1, 1'(term_eop && n == 0));
        for (int i = 0; i < n; i++) begin
            if (i == toggle_at) enable = ~enable;
            send_word(pix_q[i], 1'b0, 1'(term_eop && i == n - 1));
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        sink_if.data  = '0;
        sink_if.valid = 1'b0;
        sink_if.sop   = 1'b0;
        sink_if.eop   = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(src_if.valid), 32'd0);
        check("rst_data", 32'(src_if.data), 32'd0);
        check("rst_sop", 32'(src_if.sop), 32'd0);
        check("rst_eop", 32'(src_if.eop), 32'd0);
        check("rst_sink_ready", 32'(sink_if.ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 4-pixel short video frame, grey ramp; hand-derived results.
        enable = 1'b1;
        pix_q = '{24'h0a0a0a, 24'h141414, 24'h1e1e1e, 24'h282828};
        exp_q.push_back({24'h000000, 1'b1, 1'b0});
        exp_q.push_back({24'h0c0c0c, 1'b0, 1'b0});
        exp_q.push_back({24'h141414, 1'b0, 1'b0});
        exp_q.push_back({24'h1e1e1e, 1'b0, 1'b0});
        exp_q.push_back({24'h252525, 1'b0, 1'b1});
        send_packet(24'h000000, 1'b1, -1, 1'b0);
        drain();

        // 2: control packet, no stalls expected with source always ready.
        stall_cycles = 0;
        pix_q = '{24'h123456, 24'habcdef};
        send_packet(24'h00000f, 1'b1, -1, 1'b1);
        check("ctrl_no_stall", 32'(stall_cycles), 32'd0);
        drain();

        // 3: bypassed video frame, then filtered frame with enable toggled mid-frame.
        enable = 1'b0;
        pix_q.delete();
        for (int i = 0; i < 6; i++) pix_q.push_back(24'($urandom));
        send_packet(24'h000020, 1'b1, -1, 1'b1);
        drain();
        enable = 1'b1;
        pix_q.delete();
        for (int i = 0; i < 5; i++) pix_q.push_back(24'($urandom));
        send_packet(24'h000030, 1'b1, 2, 1'b1);
        drain();
        enable = 1'b1;

        // 5: sop after 3 pixels drops held pixels, then a normal short frame.
        pix_q.delete();
        for (int i = 0; i < 3; i++) pix_q.push_back(24'($urandom));
        send_packet(24'h000040, 1'b0, -1, 1'b1);
        pix_q.delete();
        for (int i = 0; i < 2; i++) pix_q.push_back(24'($urandom));
        send_packet(24'h000050, 1'b1, -1, 1'b1);
        drain();

        // 6a: saturated pixels and a single-pixel line.
        pix_q = '{24'hffffff, 24'hffffff, 24'hffffff};
        exp_q.push_back({24'h000000, 1'b1, 1'b0});
        exp_q.push_back({24'hffffff, 1'b0, 1'b0});
        exp_q.push_back({24'hffffff, 1'b0, 1'b0});
        exp_q.push_back({24'hffffff, 1'b0, 1'b1});
        send_packet(24'h000000, 1'b1, -1, 1'b0);
        pix_q = '{24'h3a7bc1};
        exp_q.push_back({24'h000000, 1'b1, 1'b0});
        exp_q.push_back({24'h3a7bc1, 1'b0, 1'b1});
        send_packet(24'h000000, 1'b1, -1, 1'b0);
        drain();

        // 4: full 640x4 frame under random backpressure and input gaps.
        rand_ready = 1'b1;
        rand_gap   = 1'b1;
        pix_q.delete();
        for (int i = 0; i < W * 4; i++) pix_q.push_back(24'($urandom));
        base = out_count;
        send_packet(24'h000060, 1'b1, -1, 1'b1);
        drain();
        check("frame_word_count", 32'(out_count - base), 32'(W * 4 + 1));
        rand_ready = 1'b0;
        rand_gap   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // 6b: reset in the middle of a filtered line.
        ignore_out = 1'b1;
        pix_q.delete();
        for (int i = 0; i < 3; i++) pix_q.push_back(24'($urandom));
        send_packet(24'h000000, 1'b0, -1, 1'b0);
        check("pre_reset_valid", 32'(src_if.valid), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_valid", 32'(src_if.valid), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        ignore_out = 1'b0;
        // After reset the block is idle: a stray word passes through unchanged.
        exp_q.push_back({24'h123456, 1'b0, 1'b0});
        send_word(24'h123456, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
